// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline stall/flush controller with multi-cycle multiply/divide tracking
module pipe_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 34
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        ex_md_start,
  input  logic        ex_md_is_div,
  input  logic        stallreq_mem,
  input  logic        excp_req,
  input  logic [31:0] excp_vector,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        md_busy,
  output logic        md_done
);
  typedef enum logic [1:0] {IDLE, MD_BUSY, FLUSH} state_t;
  localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
  localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [31:0] vec, vec_nxt;
  logic        md_stall;
  // state, busy counter and redirect target registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      vec   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      vec   <= vec_nxt;
    end
  // next state: an exception preempts everything, including an in-flight multiply/divide
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vec_nxt   = vec;
    if (excp_req) begin
      state_nxt = FLUSH;
      cnt_nxt   = '0;
      vec_nxt   = excp_vector;
    end else begin
      case (state)
        IDLE: if (ex_md_start) begin
          state_nxt = MD_BUSY;
          cnt_nxt   = ex_md_is_div ? DIV_LOAD : MUL_LOAD;
        end
        MD_BUSY: if (cnt != '0) cnt_nxt = cnt - 6'd1;
                 else if (!stallreq_mem) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end
  // outputs: stall priority chain, flush pulse and unit status
  always_comb begin
    md_stall = (state == IDLE && ex_md_start) || (state == MD_BUSY && cnt != '0);
    stall    = excp_req        ? 6'b000000 :
               state == FLUSH  ? 6'b000000 :
               stallreq_mem    ? 6'b011111 :
               md_stall        ? 6'b001111 :
               stallreq_id     ? 6'b000111 :
               stallreq_if     ? 6'b000011 : 6'b000000;
    flush    = state == FLUSH;
    new_pc   = flush ? vec : 32'h0;
    md_busy  = state == MD_BUSY;
    md_done  = md_busy && cnt == '0;
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboard bench for pipe_ctrl
module tb_pipe_ctrl;
  typedef struct packed {
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] pc;
    logic        busy;
    logic        done;
  } exp_t;
  localparam logic [5:0] IF = 6'b100000, ID = 6'b010000, ST = 6'b001000,
                         DV = 6'b000100, MEM = 6'b000010, EX = 6'b000001, NO = 6'b000000;
  logic        clk = 0, rst = 1;
  logic        stallreq_if = 0, stallreq_id = 0, ex_md_start = 0, ex_md_is_div = 0;
  logic        stallreq_mem = 0, excp_req = 0;
  logic [31:0] excp_vector = 0;
  logic [5:0]  stall;
  logic        flush, md_busy, md_done;
  logic [31:0] new_pc;
  exp_t        q[$];
  string       tname = "reset";
  int          n_vec = 0, n_bad = 0;

  pipe_ctrl dut (
    .clk(clk), .rst(rst), .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .ex_md_start(ex_md_start), .ex_md_is_div(ex_md_is_div), .stallreq_mem(stallreq_mem),
    .excp_req(excp_req), .excp_vector(excp_vector), .stall(stall), .flush(flush),
    .new_pc(new_pc), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  function automatic exp_t E(input logic [5:0] s, input logic f, input logic [31:0] p,
                             input logic b, input logic d);
    E = '{stall: s, flush: f, pc: p, busy: b, done: d};
  endfunction

  // drive one cycle of stimulus and queue the outputs it should produce
  task automatic cyc(input string tag, input logic r, input logic [5:0] rq,
                     input logic [31:0] ev, input exp_t e);
    @(posedge clk);
    #1;
    tname = tag;
    rst = r;
    {stallreq_if, stallreq_id, ex_md_start, ex_md_is_div, stallreq_mem, excp_req} = rq;
    excp_vector = ev;
    q.push_back(e);
  endtask

  always @(negedge clk)
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({tname, ".stall"}, 32'(stall), 32'(e.stall));
      chk({tname, ".flush"}, 32'(flush), 32'(e.flush));
      chk({tname, ".new_pc"}, new_pc, e.pc);
      chk({tname, ".md_busy"}, 32'(md_busy), 32'(e.busy));
      chk({tname, ".md_done"}, 32'(md_done), 32'(e.done));
    end

  initial begin
    exp_t idle;
    idle = E(6'b000000, 0, 0, 0, 0);
    cyc("reset", 1, NO, 0, idle);
    cyc("reset_if", 1, IF, 0, E(6'b000011, 0, 0, 0, 0));
    cyc("idle", 0, NO, 0, idle);
    cyc("mem_id", 0, MEM | ID, 0, E(6'b011111, 0, 0, 0, 0));
    cyc("if_only", 0, IF, 0, E(6'b000011, 0, 0, 0, 0));
    cyc("id_if", 0, ID | IF, 0, E(6'b000111, 0, 0, 0, 0));
    cyc("excp_mem", 0, EX | MEM, 32'h1234_5678, E(6'b000000, 0, 0, 0, 0));
    cyc("flush_pulse", 0, NO, 0, E(6'b000000, 1, 32'h1234_5678, 0, 0));
    cyc("after_flush", 0, NO, 0, idle);
    // multiply: 4 stall cycles, done on cycle 5, restart ignored while busy
    cyc("mul_start", 0, ST, 0, E(6'b001111, 0, 0, 0, 0));
    for (int i = 2; i <= 4; i++) cyc("mul_busy", 0, ST | ID, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("mul_done", 0, ST | ID, 0, E(6'b000111, 0, 0, 1, 1));
    cyc("mul_idle", 0, NO, 0, idle);
    // multiply finishing under a memory stall holds md_done
    cyc("mulm_start", 0, ST, 0, E(6'b001111, 0, 0, 0, 0));
    cyc("mulm_busy", 0, NO, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("mulm_busy", 0, NO, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("mulm_cnt1", 0, MEM, 0, E(6'b011111, 0, 0, 1, 0));
    cyc("mulm_hold", 0, MEM, 0, E(6'b011111, 0, 0, 1, 1));
    cyc("mulm_hold", 0, MEM, 0, E(6'b011111, 0, 0, 1, 1));
    cyc("mulm_rel", 0, NO, 0, E(6'b000000, 0, 0, 1, 1));
    cyc("mulm_idle", 0, NO, 0, idle);
    // full divide: 34 stall cycles, done on cycle 35
    cyc("div_start", 0, ST | DV, 0, E(6'b001111, 0, 0, 0, 0));
    for (int i = 2; i <= 34; i++) cyc("div_busy", 0, NO, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("div_done", 0, NO, 0, E(6'b000000, 0, 0, 1, 1));
    cyc("div_idle", 0, NO, 0, idle);
    // divide aborted by an exception on busy cycle 10, then recaptured during flush
    cyc("dx_start", 0, ST | DV, 0, E(6'b001111, 0, 0, 0, 0));
    for (int i = 2; i <= 9; i++) cyc("dx_busy", 0, NO, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("dx_excp", 0, EX, 32'hBFC0_0380, E(6'b000000, 0, 0, 1, 0));
    cyc("dx_flush", 0, EX, 32'h8000_0180, E(6'b000000, 1, 32'hBFC0_0380, 0, 0));
    cyc("dx_reflush", 0, MEM, 0, E(6'b000000, 1, 32'h8000_0180, 0, 0));
    cyc("dx_idle", 0, NO, 0, idle);
    for (int i = 0; i < 30; i++) cyc("dx_nodone", 0, NO, 0, idle);
    // reset mid-divide abandons the operation
    cyc("dr_start", 0, ST | DV, 0, E(6'b001111, 0, 0, 0, 0));
    for (int i = 2; i <= 5; i++) cyc("dr_busy", 0, NO, 0, E(6'b001111, 0, 0, 1, 0));
    cyc("dr_rst", 1, NO, 0, idle);
    for (int i = 0; i < 40; i++) cyc("dr_nodone", 0, NO, 0, idle);
    // reset mid-flush drops the pulse
    cyc("fr_excp", 0, EX, 32'hDEAD_BEEF, idle);
    cyc("fr_rst", 1, NO, 0, idle);
    cyc("fr_idle", 0, NO, 0, idle);
    cyc("fr_idle", 0, NO, 0, idle);
    @(posedge clk);
    @(posedge clk);
    chk("drain", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
